// File: rtl/irq_interval_capture.sv
// Measures the cycle interval between accepted rising edges of an interrupt line and hands each completed interval to the history buffer.
// Latency: capture is registered, so shift_en/new_value appear one cycle after the edge-sampling cycle; defining IRQ_SYNC_EN adds a 2-flop input synchroniser, which delays this by 2 more cycles.
// Backpressure: none. The shift_en strobe is fire-and-forget, and the history buffer must accept it in the cycle it appears.
module irq_interval_capture #(
    parameter int DATA_WIDTH    = 32,
    parameter int EVT_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic                     irq_in,
    output logic                     shift_en,
    output logic [DATA_WIDTH-1:0]    new_value,
    output logic [EVT_CNT_WIDTH-1:0] event_count,
    output logic                     interval_sat,
    output logic                     busy
);

    // Two states only: waiting for the first edge of a run, or timing an interval.
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

    localparam logic [DATA_WIDTH-1:0]    CNT_MAX = '1;
    localparam logic [DATA_WIDTH-1:0]    CNT_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0]    CNT_ZERO = '0;
    localparam logic [EVT_CNT_WIDTH-1:0] EVT_ONE = {{(EVT_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [EVT_CNT_WIDTH-1:0] EVT_ZERO = '0;

    // Registered state
    logic [0:0]               r_state;
    logic [DATA_WIDTH-1:0]    r_cnt;
    logic                     r_irq_d;
    logic                     r_shift_en;
    logic [DATA_WIDTH-1:0]    r_new_value;
    logic [EVT_CNT_WIDTH-1:0] r_evt_cnt;
    logic                     r_sat;

    // Combinational next-state values
    logic                     w_irq;
    logic                     w_rise;
    logic                     w_accept;
    logic                     w_cnt_at_max;
    logic [0:0]               w_state_nxt;
    logic [DATA_WIDTH-1:0]    w_cnt_nxt;
    logic                     w_shift_nxt;
    logic [DATA_WIDTH-1:0]    w_new_value_nxt;
    logic [EVT_CNT_WIDTH-1:0] w_evt_cnt_nxt;
    logic                     w_sat_nxt;

`ifdef IRQ_SYNC_EN
    logic r_sync_meta;
    logic r_sync_irq;

    // Two-flop synchroniser, so that irq_in may come from another clock domain.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync_meta <= 1'b0;
            r_sync_irq  <= 1'b0;
        end else begin
            r_sync_meta <= irq_in;
            r_sync_irq  <= r_sync_meta;
        end
    end

    assign w_irq = r_sync_irq;
`else
    // irq_in is already synchronous to clk, so it feeds edge detection directly.
    assign w_irq = irq_in;
`endif

    // Edge-detect history. It runs regardless of enable, so that a line which is
    // already high when enable rises does not look like a fresh edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_irq_d <= 1'b0;
        end else begin
            r_irq_d <= w_irq;
        end
    end

    assign w_rise       = w_irq & ~r_irq_d;
    assign w_accept     = w_rise & enable & ~clear;
    assign w_cnt_at_max = (r_cnt == CNT_MAX);

    // Next-state logic. Priority order: clear, then enable-low abort, then the edge/count behaviour.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_shift_nxt     = 1'b0;
        w_new_value_nxt = r_new_value;
        w_evt_cnt_nxt   = r_evt_cnt;
        w_sat_nxt       = r_sat;

        if (clear) begin
            // new_value is deliberately kept so the last reported interval remains readable.
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = CNT_ZERO;
            w_evt_cnt_nxt = EVT_ZERO;
            w_sat_nxt     = 1'b0;
        end else if (!enable) begin
            // Drop any partial interval. The counter is reloaded on the next accepted edge.
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // The first edge of a run only starts timing; there is nothing to report yet.
                        w_state_nxt   = ST_COUNTING;
                        w_cnt_nxt     = CNT_ONE;
                        w_evt_cnt_nxt = r_evt_cnt + EVT_ONE;
                    end
                end
                ST_COUNTING: begin
                    if (w_accept) begin
                        // Report the finished interval, then restart timing from this edge.
                        w_new_value_nxt = r_cnt;
                        w_shift_nxt     = 1'b1;
                        w_cnt_nxt       = CNT_ONE;
                        w_evt_cnt_nxt   = r_evt_cnt + EVT_ONE;
                        if (w_cnt_at_max) begin
                            w_sat_nxt = 1'b1;
                        end
                    end else if (!w_cnt_at_max) begin
                        w_cnt_nxt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // State and interval counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Registered outputs toward the history buffer, plus the status counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shift_en  <= 1'b0;
            r_new_value <= CNT_ZERO;
            r_evt_cnt   <= EVT_ZERO;
            r_sat       <= 1'b0;
        end else begin
            r_shift_en  <= w_shift_nxt;
            r_new_value <= w_new_value_nxt;
            r_evt_cnt   <= w_evt_cnt_nxt;
            r_sat       <= w_sat_nxt;
        end
    end

    assign shift_en     = r_shift_en;
    assign new_value    = r_new_value;
    assign event_count  = r_evt_cnt;
    assign interval_sat = r_sat;
    assign busy         = (r_state == ST_COUNTING);

endmodule
